// File: rtl/rr_timeout_arbiter.sv
// Round-robin / fixed-priority arbiter with a per-grant hold budget.
// A granted port keeps the grant while it requests and has budget left
// (L+1 cycles for budget L); running out of budget while still requesting
// produces a one-cycle timeout pulse. Handover to the next winner happens
// on the release edge itself, so there is no idle bubble between owners.
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | no port granted, waiting for any request
// S_BUSY | one port owns grant, cnt counts its held cycles
module rr_timeout_arbiter #(
  parameter int NPORTS = 5,
  parameter int LEN_W  = 12,
  parameter int ID_W   = 3,
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORTS-1:0]       req,
  input  logic [NPORTS*ID_W-1:0]  flit_id,
  input  logic [NPORTS*LEN_W-1:0] length,
  output logic [NPORTS-1:0]       grant,
  output logic                    grant_valid,
  output logic [NPORTS-1:0]       timeout
);

  localparam int OW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            state;
  logic [OW-1:0]     last_owner;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  limit;

  logic              found;
  logic [OW-1:0]     win;
  logic [NPORTS-1:0] win_oh;
  logic [NPORTS-1:0] own_oh;
  logic              own_req;
  logic [LEN_W-1:0]  win_len;
  int                best_d;
  int                d;

  // flit ids travel alongside the requests but never steer arbitration
  logic unused_flit_id;
  assign unused_flit_id = ^flit_id;

  // Winner search: each requester gets a priority distance, smallest wins.
  // Round-robin measures distance from last_owner+1 (the previous owner lands
  // at distance NPORTS, i.e. last); fixed priority just uses the index.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    best_d = NPORTS + 1;
    d      = 0;
    for (int i = 0; i < NPORTS; i++) begin
      if (req[i]) begin
        if (MODE == 1) begin
          d = i + 1;
        end else begin
          d = i - int'(last_owner);
          if (d <= 0) d = d + NPORTS;
        end
        if (d < best_d) begin
          best_d = d;
          win    = OW'(i);
          found  = 1'b1;
        end
      end
    end
  end

  // Decode winner / current owner into one-hot form and pick the winner's budget
  always_comb begin
    win_oh  = '0;
    own_oh  = '0;
    win_len = '0;
    for (int i = 0; i < NPORTS; i++) begin
      win_oh[i] = found && (OW'(i) == win);
      own_oh[i] = (OW'(i) == last_owner);
      if (found && (OW'(i) == win)) win_len = length[i*LEN_W +: LEN_W];
    end
    own_req = |(req & own_oh);
  end

  // Grant FSM: hold while budget remains, otherwise release and hand over on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      timeout     <= '0;
      cnt         <= '0;
      limit       <= '0;
      last_owner  <= OW'(NPORTS - 1);
    end else begin
      timeout <= '0;
      if (state == S_BUSY && own_req && cnt < limit) begin
        cnt <= cnt + 1'b1;
      end else begin
        // still requesting at release means the budget ran out
        if (state == S_BUSY && own_req) timeout <= own_oh;
        if (found) begin
          state       <= S_BUSY;
          grant       <= win_oh;
          grant_valid <= 1'b1;
          limit       <= win_len;
          cnt         <= '0;
          last_owner  <= win;
        end else begin
          state       <= S_IDLE;
          grant       <= '0;
          grant_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Bench for rr_timeout_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model for both arbitration modes.
module tb_rr_timeout_arbiter;

  localparam int N  = 5;
  localparam int LW = 12;
  localparam int IW = 3;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*IW-1:0] flit_id;
  logic [N*LW-1:0] length;
  logic [N-1:0]    grant0, timeout0, grant1, timeout1;
  logic            gv0, gv1;

  int vectors     = 0;
  int miscompares = 0;

  rr_timeout_arbiter #(.NPORTS(N), .LEN_W(LW), .ID_W(IW), .MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .length(length),
    .grant(grant0), .grant_valid(gv0), .timeout(timeout0)
  );

  rr_timeout_arbiter #(.NPORTS(N), .LEN_W(LW), .ID_W(IW), .MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .length(length),
    .grant(grant1), .grant_valid(gv1), .timeout(timeout1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural model, index 0 = round-robin, 1 = fixed priority
  int         m_owner  [2];
  int         m_last   [2];
  int         m_given  [2];
  int         m_budget [2];
  logic [N-1:0] m_grant [2];
  logic [N-1:0] m_to    [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m]  = -1;
      m_last[m]   = N - 1;
      m_given[m]  = 0;
      m_budget[m] = 0;
      m_grant[m]  = '0;
      m_to[m]     = '0;
    end
  endtask

  function automatic int pick(input int m, input int start);
    if (m == 1) begin
      for (int i = 0; i < N; i++) if (req[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input int m);
    int nxt;
    m_to[m] = '0;
    // a port with budget L is entitled to L+1 grant cycles in a row
    if (m_owner[m] >= 0 && req[m_owner[m]] && m_given[m] < m_budget[m] + 1) begin
      m_given[m]++;
    end else begin
      if (m_owner[m] >= 0 && req[m_owner[m]]) m_to[m][m_owner[m]] = 1'b1;
      nxt = pick(m, (m_owner[m] >= 0) ? m_owner[m] : m_last[m]);
      if (nxt >= 0) begin
        m_owner[m]  = nxt;
        m_last[m]   = nxt;
        m_given[m]  = 1;
        m_budget[m] = int'(length[nxt*LW +: LW]);
      end else begin
        m_owner[m] = -1;
      end
    end
    m_grant[m] = (m_owner[m] >= 0) ? N'(1 << m_owner[m]) : '0;
  endtask

  // one rising edge; inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic set_len(input int p, input int v);
    length[p*LW +: LW] = LW'(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    length = '0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; length = '0; flit_id = '0;
    #1 rst = 1'b0;
    #2;
    vectors++;
    if ({grant0, gv0, timeout0} !== '0) begin
      miscompares++;
      $display("FAIL reset_rr: got %b want 0", {grant0, gv0, timeout0});
    end
    vectors++;
    if ({grant1, gv1, timeout1} !== '0) begin
      miscompares++;
      $display("FAIL reset_fp: got %b want 0", {grant1, gv1, timeout1});
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_single_timeout();
    do_reset();
    set_len(0, 3);
    req = 5'b00001;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (grant0 !== 5'b00001 || timeout0 !== 5'b00000) begin
        miscompares++;
        $display("FAIL hold_l3 cyc%0d: got grant %b to %b want grant 00001 to 00000", c, grant0, timeout0);
      end
    end
    tick();
    vectors++;
    if (grant0 !== 5'b00001 || timeout0 !== 5'b00001 || gv0 !== 1'b1) begin
      miscompares++;
      $display("FAIL expiry_regrant: got grant %b to %b gv %b want grant 00001 to 00001 gv 1", grant0, timeout0, gv0);
    end
    tick();
    vectors++;
    if (timeout0 !== 5'b00000) begin
      miscompares++;
      $display("FAIL to_one_cycle: got %b want 00000", timeout0);
    end
  endtask

  task automatic test_rr_zero_len();
    logic [N-1:0] exp_g [4];
    logic [N-1:0] exp_t [4];
    exp_g = '{5'b00001, 5'b00100, 5'b10000, 5'b00001};
    exp_t = '{5'b00000, 5'b00001, 5'b00100, 5'b10000};
    do_reset();
    req = 5'b10101;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (grant0 !== exp_g[c] || timeout0 !== exp_t[c]) begin
        miscompares++;
        $display("FAIL rr_seq cyc%0d: got grant %b to %b want grant %b to %b", c, grant0, timeout0, exp_g[c], exp_t[c]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    set_len(3, 2);
    req = 5'b11000;
    tick();
    vectors++;
    if (grant1 !== 5'b01000) begin
      miscompares++;
      $display("FAIL fp_first: got %b want 01000", grant1);
    end
    req = 5'b11001;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if (grant1 !== 5'b01000) begin
        miscompares++;
        $display("FAIL fp_hold cyc%0d: got %b want 01000", c, grant1);
      end
    end
    tick();
    vectors++;
    if (grant1 !== 5'b00001 || timeout1 !== 5'b01000) begin
      miscompares++;
      $display("FAIL fp_handover: got grant %b to %b want grant 00001 to 01000", grant1, timeout1);
    end
  endtask

  task automatic test_drop();
    do_reset();
    set_len(2, 10);
    req = 5'b00100;
    for (int c = 0; c < 4; c++) tick();
    vectors++;
    if (grant0 !== 5'b00100) begin
      miscompares++;
      $display("FAIL drop_pre: got %b want 00100", grant0);
    end
    req = '0;
    tick();
    vectors++;
    if (grant0 !== 5'b00000 || gv0 !== 1'b0 || timeout0 !== 5'b00000) begin
      miscompares++;
      $display("FAIL drop_release: got grant %b gv %b to %b want 00000 0 00000", grant0, gv0, timeout0);
    end
  endtask

  task automatic test_length_change();
    do_reset();
    set_len(1, 4);
    req = 5'b00010;
    tick();
    set_len(1, 0);
    for (int c = 1; c < 5; c++) begin
      tick();
      vectors++;
      if (grant0 !== 5'b00010 || timeout0 !== 5'b00000) begin
        miscompares++;
        $display("FAIL len_change cyc%0d: got grant %b to %b want 00010 00000", c, grant0, timeout0);
      end
    end
    tick();
    vectors++;
    if (timeout0 !== 5'b00010) begin
      miscompares++;
      $display("FAIL len_change_expiry: got %b want 00010", timeout0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_len(1, 10);
    req = 5'b00010;
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b0;
    #1;
    vectors++;
    if ({grant0, gv0, timeout0} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got %b want 0", {grant0, gv0, timeout0});
    end
    req = 5'b00110;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    tick();
    vectors++;
    if (grant0 !== 5'b00010 || timeout0 !== 5'b00000) begin
      miscompares++;
      $display("FAIL restart_grant: got grant %b to %b want 00010 00000", grant0, timeout0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int p = 0; p < N; p++) set_len(p, $urandom_range(0, 5));
    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 99) begin
        rst = 1'b0;
        #1;
        vectors++;
        if ({grant0, gv0, timeout0, grant1, gv1, timeout1} !== '0) begin
          miscompares++;
          $display("FAIL rand_reset c%0d: got %b want 0", c, {grant0, gv0, timeout0, grant1, gv1, timeout1});
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
      end
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 9) < 6);
      end
      if ($urandom_range(0, 3) == 0) set_len($urandom_range(0, N - 1), $urandom_range(0, 5));
      flit_id = (N*IW)'($urandom);
      tick();
      vectors++;
      if (grant0 !== m_grant[0] || timeout0 !== m_to[0] || gv0 !== (|m_grant[0])) begin
        miscompares++;
        $display("FAIL rand_rr c%0d: got g %b t %b v %b want g %b t %b v %b", c, grant0, timeout0, gv0, m_grant[0], m_to[0], |m_grant[0]);
      end
      vectors++;
      if (grant1 !== m_grant[1] || timeout1 !== m_to[1] || gv1 !== (|m_grant[1])) begin
        miscompares++;
        $display("FAIL rand_fp c%0d: got g %b t %b v %b want g %b t %b v %b", c, grant1, timeout1, gv1, m_grant[1], m_to[1], |m_grant[1]);
      end
      vectors++;
      if ($countones(grant0) > 1 || $countones(grant1) > 1) begin
        miscompares++;
        $display("FAIL onehot c%0d: got %b %b want at most one bit each", c, grant0, grant1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_timeout();
    test_rr_zero_len();
    test_fixed_priority();
    test_drop();
    test_length_change();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
